// File: rtl/msg_encoder.sv
// Order-entry message encoder: validates requests, queues them in a small FIFO and
// serialises them into fixed 168-bit frames, with heartbeat frames on idle.
module msg_encoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int HB_IDLE    = 1000,
   parameter int PRICE_MIN  = 50,
   parameter int PRICE_MAX  = 149
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_side,
   input  logic [31:0]  req_price,
   input  logic [31:0]  req_qty,
   output logic [167:0] msg,
   output logic         msg_valid,
   input  logic         msg_ready,
   output logic         reject
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
   localparam logic [31:0]   PMIN    = PRICE_MIN[31:0];
   localparam logic [31:0]   PMAX    = PRICE_MAX[31:0];
   localparam logic [31:0]   HB_C    = HB_IDLE[31:0];
   localparam logic [7:0]    TYPE_ADD = 8'd0;
   localparam logic [7:0]    TYPE_HB  = 8'd1;

   function automatic logic req_ok(input logic [31:0] price, input logic [31:0] qty);
      return (qty != 32'd0) && (price >= PMIN) && (price <= PMAX);
   endfunction

   function automatic logic [167:0] build_frame(input logic [7:0] ftype, input logic [31:0] fseq,
                                                input logic fside, input logic [31:0] foid,
                                                input logic [31:0] fprice, input logic [31:0] fqty);
      return {24'd0, fqty, fprice, foid, 7'd0, fside, fseq, ftype};
   endfunction

   logic [64:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   seq;
   logic [31:0]   oid;
   logic [31:0]   idle;

   logic        full;
   logic        empty;
   logic        accept;
   logic        push;
   logic        pop;
   logic        out_free;
   logic        hb_load;
   logic [64:0] head;

   assign full      = (count == DEPTH_C);
   assign empty     = (count == '0);
   assign req_ready = !rst && !full;
   assign accept    = req_valid && req_ready;
   assign push      = accept && req_ok(req_price, req_qty);
   assign out_free  = !msg_valid || msg_ready;
   assign pop       = out_free && !empty;
   // A request handshake in the same cycle suppresses the heartbeat.
   assign hb_load   = out_free && empty && !accept && (idle == HB_C);
   assign head      = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {req_side, req_price, req_qty};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         msg       <= '0;
         msg_valid <= 1'b0;
         reject    <= 1'b0;
         seq       <= '0;
         oid       <= '0;
         idle      <= '0;
      end else begin
         reject <= accept && !req_ok(req_price, req_qty);

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (!push && pop) count <= count - (AW+1)'(1);

         if (pop) begin
            msg       <= build_frame(TYPE_ADD, seq, head[64], oid, head[63:32], head[31:0]);
            msg_valid <= 1'b1;
            seq       <= seq + 32'd1;
            oid       <= oid + 32'd1;
         end else if (hb_load) begin
            msg       <= build_frame(TYPE_HB, seq, 1'b0, 32'd0, 32'd0, 32'd0);
            msg_valid <= 1'b1;
            seq       <= seq + 32'd1;
         end else if (msg_valid && msg_ready) begin
            msg_valid <= 1'b0;
         end

         if (hb_load)
            idle <= '0;
         else if (empty && !msg_valid && !accept)
            idle <= idle + 32'd1;
         else
            idle <= '0;
      end
   end

endmodule

// File: tb/tb_msg_encoder.sv
// Scoreboard bench for msg_encoder: stimulus pushes expected frames, a monitor pops
// and compares them on every output handshake.
module tb_msg_encoder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_side = 1'b0;
   logic [31:0]  req_price = '0;
   logic [31:0]  req_qty = '0;
   logic [167:0] msg;
   logic         msg_valid;
   logic         msg_ready = 1'b0;
   logic         reject;

   int checks = 0;
   int errors = 0;
   int rej_cnt = 0;
   logic [31:0] exp_seq = '0;
   logic [31:0] exp_id = '0;
   logic [167:0] q[$];

   logic         hold = 1'b0;
   logic [167:0] hold_msg = '0;

   msg_encoder #(.FIFO_DEPTH(4), .HB_IDLE(8), .PRICE_MIN(50), .PRICE_MAX(149)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_side(req_side), .req_price(req_price), .req_qty(req_qty),
      .msg(msg), .msg_valid(msg_valid), .msg_ready(msg_ready), .reject(reject)
   );

   always #5 clk = ~clk;

   function automatic logic [167:0] mk(input logic [7:0] t, input logic [31:0] s, input logic sd,
                                       input logic [31:0] id, input logic [31:0] p, input logic [31:0] qv);
      return {24'd0, qv, p, id, 7'd0, sd, s, t};
   endfunction

   task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: frame compare on handshake, hold-stability while stalled, reject counting.
   always @(negedge clk) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            checks++;
            if (msg_valid !== 1'b1 || msg !== hold_msg) begin
               errors++;
               $display("FAIL stable: got v=%b %h expected v=1 %h", msg_valid, msg, hold_msg);
            end
         end
         if (msg_valid && msg_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got %h expected none", msg);
            end else begin
               chk("frame", msg, q.pop_front());
            end
         end
         hold = msg_valid && !msg_ready;
         hold_msg = msg;
         if (reject) rej_cnt++;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = 1'b0;
      q.delete();
      exp_seq = '0;
      exp_id = '0;
      @(negedge clk);
      chk("rst_req_ready", {167'd0, req_ready}, 168'd0);
      @(posedge clk); #1;
      chk("rst_msg_valid", {167'd0, msg_valid}, 168'd0);
      chk("rst_msg", msg, 168'd0);
      chk("rst_reject", {167'd0, reject}, 168'd0);
      rst = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic send(input logic s, input logic [31:0] p, input logic [31:0] qv, input logic ok);
      int n;
      n = 0;
      req_side = s;
      req_price = p;
      req_qty = qv;
      req_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=0 expected 1");
            break;
         end
         @(posedge clk); #1;
      end
      if (ok) begin
         q.push_back(mk(8'd0, exp_seq, s, exp_id, p, qv));
         exp_seq++;
         exp_id++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (q.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 168'(q.size()), 168'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r0;
      repeat (2) @(posedge clk);

      // Single order: latency and field placement
      do_reset();
      msg_ready = 1'b1;
      send(1'b0, 32'd60, 32'd10, 1'b1);
      @(negedge clk);
      chk("lat_cycle1", {167'd0, msg_valid}, 168'd0);
      @(negedge clk);
      chk("lat_cycle2", {167'd0, msg_valid}, 168'd1);
      chk("upper_zero", {144'd0, msg[167:144]}, 168'd0);
      wait_drain(20);

      // Backpressure: 1 in output register + 4 in FIFO, then full
      do_reset();
      msg_ready = 1'b0;
      send(1'b0, 32'd60, 32'd1, 1'b1);
      send(1'b1, 32'd61, 32'd2, 1'b1);
      send(1'b0, 32'd62, 32'd3, 1'b1);
      send(1'b1, 32'd63, 32'd4, 1'b1);
      send(1'b0, 32'd64, 32'd5, 1'b1);
      req_side = 1'b1; req_price = 32'd65; req_qty = 32'd6; req_valid = 1'b1;
      @(negedge clk);
      chk("full_ready", {167'd0, req_ready}, 168'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      msg_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("burst_valid", {167'd0, msg_valid}, 168'd1);
      end
      @(negedge clk);
      chk("burst_end", {167'd0, msg_valid}, 168'd0);
      wait_drain(20);

      // Rejects consume nothing; boundary prices accepted
      do_reset();
      msg_ready = 1'b1;
      r0 = rej_cnt;
      send(1'b0, 32'd60, 32'd0, 1'b0);
      send(1'b0, 32'd49, 32'd1, 1'b0);
      send(1'b1, 32'd150, 32'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("reject_count", 168'(rej_cnt - r0), 168'd3);
      chk("reject_no_msg", {167'd0, msg_valid}, 168'd0);
      @(posedge clk); #1;
      send(1'b1, 32'd149, 32'd7, 1'b1);
      send(1'b0, 32'd50, 32'd2, 1'b1);
      wait_drain(20);

      // Heartbeat after idle, then an order with seq 1 / id 0
      do_reset();
      msg_ready = 1'b1;
      q.push_back(mk(8'd1, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0));
      exp_seq = 32'd1;
      wait_drain(30);
      send(1'b1, 32'd70, 32'd3, 1'b1);
      wait_drain(20);

      // Order handshake in the very cycle the heartbeat would fire wins
      do_reset();
      msg_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      send(1'b0, 32'd90, 32'd4, 1'b1);
      wait_drain(20);

      // Reset mid-operation discards pending frames
      do_reset();
      msg_ready = 1'b0;
      send(1'b0, 32'd60, 32'd1, 1'b0);
      send(1'b0, 32'd61, 32'd1, 1'b0);
      send(1'b0, 32'd62, 32'd1, 1'b0);
      send(1'b0, 32'd63, 32'd1, 1'b0);
      @(negedge clk);
      chk("pre_reset_valid", {167'd0, msg_valid}, 168'd1);
      do_reset();
      @(negedge clk);
      chk("post_reset_valid", {167'd0, msg_valid}, 168'd0);
      @(posedge clk); #1;
      msg_ready = 1'b1;
      send(1'b1, 32'd80, 32'd9, 1'b1);
      wait_drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/msg_encoder.md
MSG_ENCODER -- requirements
Module: msg_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request FIFO depth in entries, a power of two and at least 2.
REQ-002 Parameter HB_IDLE, default 1000: idle cycles before a heartbeat message is emitted.
REQ-003 Parameter PRICE_MIN, default 50; parameter PRICE_MAX, default 149: inclusive legal price range (100 book levels).
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  order request present.
REQ-007 req_ready  output  1  encoder accepts request this cycle.
REQ-008 req_side  input  1  0 = bid, 1 = ask.
REQ-009 req_price  input  32  unsigned price.
REQ-010 req_qty  input  32  unsigned quantity.
REQ-011 msg  output  168  encoded message frame.
REQ-012 msg_valid  output  1  msg holds an unsent frame.
REQ-013 msg_ready  input  1  downstream consumes msg this cycle.
REQ-014 reject  output  1  one-cycle pulse: an accepted request was dropped as invalid.

Function
REQ-015 Frame layout: [7:0] type (0 = add order, 1 = heartbeat); [39:8] seq; [47:40] side (0/1, zero-extended); [79:48] order id; [111:80] price; [143:112] qty; [167:144] always zero.
REQ-016 Heartbeat frames carry zero in side, order id, price and qty.
REQ-017 Request handshake occurs when req_valid && req_ready; req_ready = !rst && FIFO not full.
REQ-018 A request with req_qty == 0, or req_price outside [PRICE_MIN, PRICE_MAX], is handshaken but not enqueued; reject is high in the following cycle only.
REQ-019 A rejected request consumes no seq and no order id.
REQ-020 A valid request is pushed into the FIFO as {side, price, qty}.
REQ-021 Output handshake occurs when msg_valid && msg_ready.
REQ-022 msg and msg_valid are stable from assertion until the output handshake.
REQ-023 The output register is free when msg_valid == 0 or an output handshake occurs in the same cycle.
REQ-024 When the output register is free and the FIFO is non-empty, pop the head, build an add-order frame, and set msg_valid next cycle.
REQ-025 Zero-wait throughput is one frame per cycle.
REQ-026 Latency: with the FIFO empty and msg_valid low, msg_valid rises 2 cycles after the request handshake.
REQ-027 Each frame takes seq = current seq counter; the counter increments by 1 (mod 2^32) when the frame loads; heartbeats consume seq.
REQ-028 Add-order frames take order id = order counter; the counter increments by 1 (mod 2^32) per add-order load.
REQ-029 Idle counter increments each cycle while the FIFO is empty, msg_valid == 0, and no request handshake occurs; otherwise it clears.
REQ-030 When the idle counter reaches HB_IDLE and the output register is free, load a heartbeat frame and clear the counter.
REQ-031 If a request handshake occurs in the cycle the idle counter reaches HB_IDLE, the order wins and no heartbeat is loaded.
REQ-032 Simultaneous FIFO push and pop on a full FIFO is not possible, since req_ready is low when full; push and pop in the same cycle on a non-empty, non-full FIFO keep occupancy unchanged.
REQ-033 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-034 Frames are emitted in request-acceptance order.

Reset
REQ-035 While rst is high:
- msg_valid = 0, msg = 0, reject = 0, req_ready = 0;
- FIFO emptied;
- seq counter, order counter and idle counter all = 0.
REQ-036 Reset mid-operation discards queued and pending frames without completing the output handshake.
REQ-037 The first frame after reset carries seq 0; the first add order carries order id 0.

Verification
REQ-038 After reset, request bid/price 60/qty 10 with msg_ready = 1 -> exactly 2 cycles later msg_valid = 1, type 0, seq 0, side 0, id 0, price 60, qty 10; upper 24 bits zero.
REQ-039 msg_ready = 0; push 5 valid requests back-to-back (FIFO_DEPTH = 4) -> the first 5 handshake with 1 in msg and 4 in the FIFO, and req_ready drops; raise msg_ready -> 5 frames, one per cycle, seq 0..4 in order.
REQ-040 Requests qty 0, price 49, then price 150 -> reject pulses 3 times, no msg_valid; the next valid request gets seq 0 and id 0.
REQ-041 HB_IDLE = 8, no requests after reset, msg_ready = 1 -> a heartbeat frame with type 1 and seq 0 appears; the next order gets seq 1 and id 0.
REQ-042 Assert rst for one cycle while msg_valid = 1 with 3 queued -> msg_valid = 0 the cycle after; the next order's frame has seq 0.
